// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
// RR_ARB_EN selects round-robin arbitration instead of fixed priority.
package regfile_wb_arbiter_pkg;

  localparam int WB_NUM_REQ = 3;
  localparam int WB_DATA_W  = 32;
  localparam int WB_ADDR_W  = 4;
  localparam int WB_CNT_W   = 2;
  localparam int NUM_REGS   = 16;

  localparam int REQ_ALU = 0;
  localparam int REQ_LD  = 1;
  localparam int REQ_LNK = 2;

endpackage

// File: rtl/regfile_wb_arbiter_arb.sv
// Write-back request arbiter: request vector in, one-hot grant out.
// RR_ARB_EN: rotating priority pointer; otherwise lowest index wins.
module wb_rr_arbiter #(
  parameter int N = 3
) (
`ifdef RR_ARB_EN
  input  logic         Clk,
  input  logic         Reset_n,
`endif
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  logic found;

`ifdef RR_ARB_EN
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_n;

  // Scan k steps past the pointer; first valid requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    ptr_n = ptr;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] &&
            i == (int'(ptr) + k) % N) begin
          grant[i] = 1'b1;
          found    = 1'b1;
          ptr_n    = (i == N - 1) ? '0
                                  : PW'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) ptr <= '0;
    else          ptr <= ptr_n;
  end
`else
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among write-back requesters and
// tracks pending writes per register. RR_ARB_EN enables round-robin.
import regfile_wb_arbiter_pkg::*;

module regfile_wb_arbiter #(
  parameter int NUM_REQ = WB_NUM_REQ,
  parameter int DATA_W  = WB_DATA_W,
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int CNT_W   = WB_CNT_W
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      IsWb,
  output logic [ADDR_W-1:0]         A3,
  output logic [DATA_W-1:0]         D3,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  output logic                      issue_ready,
  input  logic [ADDR_W-1:0]         rd_addr1,
  input  logic [ADDR_W-1:0]         rd_addr2,
  output logic                      hazard1,
  output logic                      hazard2,
  output logic                      sb_err
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  logic [ADDR_W-1:0]  wa;
  logic [DATA_W-1:0]  wd;
  logic               inc;
  logic               up;
  logic               dn;
  logic               err_set;
  logic [CNT_W-1:0]   cnt   [NREG];
  logic [CNT_W-1:0]   cnt_n [NREG];

  wb_rr_arbiter #(.N(NUM_REQ)) u_arb (
`ifdef RR_ARB_EN
    .Clk     (Clk),
    .Reset_n (Reset_n),
`endif
    .req     (req_valid),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    wa = '0;
    wd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        wa = req_addr[i*ADDR_W +: ADDR_W];
        wd = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign issue_ready = (cnt[issue_addr] != CNT_MAX);
  assign inc         = issue_valid && issue_ready;
  assign hazard1     = (cnt[rd_addr1] != '0);
  assign hazard2     = (cnt[rd_addr2] != '0);

  // Issue and retire on the same register cancel out.
  always_comb begin
    err_set = 1'b0;
    up      = 1'b0;
    dn      = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      cnt_n[r] = cnt[r];
      up = inc  && (issue_addr == ADDR_W'(r));
      dn = xfer && (wa == ADDR_W'(r));
      if (up && !dn) begin
        cnt_n[r] = cnt[r] + CNT_W'(1);
      end else if (dn && !up) begin
        if (cnt[r] == '0) err_set  = 1'b1;
        else              cnt_n[r] = cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      IsWb   <= 1'b0;
      A3     <= '0;
      D3     <= '0;
      sb_err <= 1'b0;
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      IsWb <= xfer;
      if (xfer) begin
        A3 <= wa;
        D3 <= wd;
      end
      if (err_set) sb_err <= 1'b1;
      cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Expected grant order follows RR_ARB_EN when it is defined.
module tb_regfile_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [11:0] req_addr;
  logic [95:0] req_data;
  logic        IsWb;
  logic [3:0]  A3;
  logic [31:0] D3;
  logic        issue_valid;
  logic [3:0]  issue_addr;
  logic        issue_ready;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic        hazard1;
  logic        hazard2;
  logic        sb_err;

  int n_chk = 0;
  int n_err = 0;

  regfile_wb_arbiter dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .IsWb        (IsWb),
    .A3          (A3),
    .D3          (D3),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .hazard1     (hazard1),
    .hazard2     (hazard2),
    .sb_err      (sb_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic put(input int i,
                     input logic [3:0] a,
                     input logic [31:0] d);
    req_valid[i]        = 1'b1;
    req_addr[i*4 +: 4]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic issue(input logic [3:0] a);
    issue_valid = 1'b1;
    issue_addr  = a;
    step();
    issue_valid = 1'b0;
  endtask

  logic [2:0] exp_g [4];
  logic [2:0] exp_101;

  initial begin
`ifdef RR_ARB_EN
    exp_g   = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_101 = 3'b100;
`else
    exp_g   = '{3'b001, 3'b001, 3'b001, 3'b001};
    exp_101 = 3'b001;
`endif
    Reset_n     = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    rd_addr1    = '0;
    rd_addr2    = '0;
    #1;
    chk("rst_iswb", 32'(IsWb), 0);
    chk("rst_sberr", 32'(sb_err), 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    // single write to r3
    issue(4'd3);
    rd_addr1 = 4'd3;
    #1 chk("t2_haz_pre", 32'(hazard1), 1);
    put(0, 4'd3, 32'hDEADBEEF);
    #1 chk("t2_ready", 32'(req_ready), 32'b001);
    step();
    req_valid = '0;
    chk("t2_iswb", 32'(IsWb), 1);
    chk("t2_a3", 32'(A3), 3);
    chk("t2_d3", D3, 32'hDEADBEEF);
    chk("t2_haz_post", 32'(hazard1), 0);
    step();
    chk("t2_iswb_low", 32'(IsWb), 0);
    chk("t2_a3_hold", 32'(A3), 3);
    chk("t2_sberr", 32'(sb_err), 0);

    // scoreboard on r7
    issue(4'd7);
    issue(4'd7);
    rd_addr1 = 4'd7;
    #1 chk("t4_haz2", 32'(hazard1), 1);
    put(1, 4'd7, 32'h77);
    step();
    chk("t4_haz1left", 32'(hazard1), 1);
    step();
    req_valid = '0;
    chk("t4_haz0", 32'(hazard1), 0);
    for (int k = 0; k < 3; k++) begin
      issue_valid = 1'b1;
      issue_addr  = 4'd7;
      #1 chk("t4_irdy", 32'(issue_ready), 1);
      step();
    end
    issue_valid = 1'b1;
    #1 chk("t4_sat", 32'(issue_ready), 0);
    step();
    issue_valid = 1'b0;
    put(1, 4'd7, 32'h78);
    step();
    step();
    chk("t4_drain2", 32'(hazard1), 1);
    step();
    req_valid = '0;
    chk("t4_drain3", 32'(hazard1), 0);
    chk("t4_sberr", 32'(sb_err), 0);

    // simultaneous issue and retire on r4
    issue(4'd4);
    rd_addr1    = 4'd4;
    issue_valid = 1'b1;
    issue_addr  = 4'd4;
    put(2, 4'd4, 32'h44);
    #1 chk("t5_ready", 32'(req_ready), 32'b100);
    step();
    issue_valid = 1'b0;
    req_valid   = '0;
    chk("t5_haz", 32'(hazard1), 1);
    put(2, 4'd4, 32'h45);
    step();
    req_valid = '0;
    chk("t5_haz0", 32'(hazard1), 0);
    chk("t5_sberr", 32'(sb_err), 0);

    // underflow on r9
    rd_addr2 = 4'd9;
    put(0, 4'd9, 32'h99);
    step();
    req_valid = '0;
    chk("t6_sberr", 32'(sb_err), 1);
    chk("t6_haz", 32'(hazard2), 0);
    chk("t6_a3", 32'(A3), 9);
    repeat (3) step();
    chk("t6_sticky", 32'(sb_err), 1);
    Reset_n = 1'b0;
    #1 chk("t6_rst", 32'(sb_err), 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // contention
    put(0, 4'd1, 32'h11);
    put(1, 4'd2, 32'h22);
    put(2, 4'd3, 32'h33);
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("t3_g%0d", k),
             32'(req_ready), 32'(exp_g[k]));
      step();
    end
    chk("t3_a3", 32'(A3), 1);
    req_valid = 3'b101;
    #1 chk("t3_g101", 32'(req_ready), 32'(exp_101));
    step();
    req_valid = 3'b010;
    #1 chk("t3_g010", 32'(req_ready), 32'b010);
    step();
    req_valid = 3'b000;
    #1 chk("t3_gnone", 32'(req_ready), 0);
    step();

    // async reset mid-stream with cnt[5]=2
    issue(4'd5);
    issue(4'd5);
    issue(4'd5);
    put(0, 4'd5, 32'h55);
    step();
    req_valid = '0;
    rd_addr1  = 4'd5;
    rd_addr2  = 4'd5;
    #1;
    chk("t1_pre_haz", 32'(hazard2), 1);
    chk("t1_pre_iswb", 32'(IsWb), 1);
    #1 Reset_n = 1'b0;
    #1;
    chk("t1_iswb", 32'(IsWb), 0);
    chk("t1_a3", 32'(A3), 0);
    chk("t1_d3", D3, 0);
    chk("t1_haz1", 32'(hazard1), 0);
    chk("t1_haz2", 32'(hazard2), 0);
    chk("t1_sberr", 32'(sb_err), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
